// File: rtl/sum_operand_sequencer.sv
// rtl/sum_operand_sequencer.sv - loads X then Y nibbles, holds them for the adder, captures {carry,o}
module sum_operand_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit CLEAR_ON_ACK  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] op_x,
  output logic [3:0] op_y,
  input  logic [3:0] sum_o,
  input  logic       sum_carry,
  output logic [4:0] res,
  output logic       res_valid,
  input  logic       res_ack,
  output logic       busy
);

  localparam logic [2:0] LOAD_X = 3'd0;
  localparam logic [2:0] LOAD_Y = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;

  // Counter starts at SETTLE_CYCLES so capture lands SETTLE_CYCLES+1 edges after Y accept.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [3:0] cnt;
  logic       xfer;

  assign xfer = in_valid && in_ready;
  assign busy = (state != LOAD_X);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD_X:  if (xfer) state_nx = LOAD_Y;
      LOAD_Y:  if (xfer) state_nx = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nx = HOLD;
      HOLD:    if (res_ack) state_nx = LOAD_X;
      default: state_nx = LOAD_X;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_X;
      in_ready  <= 1'b1;
      op_x      <= 4'd0;
      op_y      <= 4'd0;
      res       <= 5'd0;
      res_valid <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == LOAD_X) || (state_nx == LOAD_Y);
      case (state)
        LOAD_X: begin
          if (xfer) op_x <= in_data;
        end
        LOAD_Y: begin
          if (xfer) begin
            op_y <= in_data;
            cnt  <= SETTLE_INIT;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res       <= {sum_carry, sum_o};
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            if (CLEAR_ON_ACK) begin
              op_x <= 4'd0;
              op_y <= 4'd0;
            end
          end
        end
        default: begin
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
